// File: rtl/vector_load_gather.sv
// Multi-cycle vector load: fetches up to VECTOR_SIZE elements one handshake at a time
// and packs them MSB-first for the vector register file. Macro: VECTOR_LOAD_STRIDE_EN.
module vector_load_gather #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy_in,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [LEN-1:0]                stride,
  input  logic [ENTRY_INDEX_SIZE:0]     length,
  input  logic [4:0]                    rd,
  output logic                          mem_req,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [LEN-1:0]                mem_rdata,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic                          wb_valid,
  output logic [VECTOR_SIZE*LEN-1:0]    wb_data,
  output logic [ENTRY_INDEX_SIZE:0]     wb_length,
  output logic [4:0]                    wb_rd
);

  localparam int CW = ENTRY_INDEX_SIZE + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           idx_reg, idx_next;
  logic [CW-1:0]           len_reg, len_next;
  logic [CW-1:0]           len_clamped;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]   step;
  logic [4:0]              rd_reg, rd_next;
  logic                    accept;
  logic                    clear;

  assign len_clamped = (length > CW'(VECTOR_SIZE)) ? CW'(VECTOR_SIZE) : length;
  assign accept      = rdy_in && (state_reg == FETCH) && mem_ready;
  assign clear       = rdy_in && (state_reg == IDLE) && start;

`ifdef VECTOR_LOAD_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_ext;
  logic [ADDR_WIDTH-1:0] stride_reg;

  // Truncation keeps two's-complement meaning modulo 2^ADDR_WIDTH; narrower strides sign-extend.
  generate
    if (LEN >= ADDR_WIDTH) begin : g_stride_trunc
      assign stride_ext = stride[ADDR_WIDTH-1:0];
    end else begin : g_stride_sext
      assign stride_ext = {{(ADDR_WIDTH-LEN){stride[LEN-1]}}, stride};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      stride_reg <= '0;
    else if (clear)
      stride_reg <= stride_ext;
  end

  assign step = stride_reg;
`else
  logic unused_stride;
  assign unused_stride = ^stride;
  assign step          = ADDR_WIDTH'(LEN / 8);
`endif

  // The address accumulates the step per accepted element, equal to base + idx*step.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    len_next   = len_reg;
    addr_next  = addr_reg;
    rd_next    = rd_reg;
    if (rdy_in) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_next   = len_clamped;
            idx_next   = '0;
            addr_next  = base_addr;
            rd_next    = rd;
            state_next = (len_clamped != '0) ? FETCH : DONE;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            idx_next  = idx_reg + CW'(1);
            addr_next = addr_reg + step;
            if (idx_reg + CW'(1) == len_reg)
              state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      len_reg   <= '0;
      addr_reg  <= '0;
      rd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      len_reg   <= len_next;
      addr_reg  <= addr_next;
      rd_reg    <= rd_next;
    end
  end

  // Element gi lands in the gi-th slot from the top, matching the register file's partial write.
  genvar gi;
  generate
    for (gi = 0; gi < VECTOR_SIZE; gi++) begin : g_slot
      logic [LEN-1:0] slot_reg;

      always_ff @(posedge clk) begin
        if (rst || clear)
          slot_reg <= '0;
        else if (accept && (idx_reg == CW'(gi)))
          slot_reg <= mem_rdata;
      end

      assign wb_data[(VECTOR_SIZE-gi)*LEN-1 -: LEN] = slot_reg;
    end
  endgenerate

  assign busy      = (state_reg != IDLE);
  assign mem_req   = (state_reg == FETCH);
  assign mem_addr  = (state_reg == FETCH) ? addr_reg : '0;
  assign wb_valid  = (state_reg == DONE);
  assign wb_length = len_reg;
  assign wb_rd     = rd_reg;

endmodule

// File: tb/tb_vector_load_gather.sv
// Directed bench for vector_load_gather: memory returns its own address as data,
// expected addresses, latencies and packed vectors are written out by hand.
module tb_vector_load_gather;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy_in;
  logic         start;
  logic [16:0]  base_addr;
  logic [31:0]  stride;
  logic [3:0]   length;
  logic [4:0]   rd;
  logic         mem_req;
  logic [16:0]  mem_addr;
  logic [31:0]  mem_rdata;
  logic         mem_ready;
  logic         busy;
  logic         wb_valid;
  logic [255:0] wb_data;
  logic [3:0]   wb_length;
  logic [4:0]   wb_rd;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] acc_q[$];
  logic [16:0] req_q[$];
  int lat;

  always #5 clk = ~clk;

  assign mem_rdata = {15'b0, mem_addr};

  vector_load_gather dut (
    .clk       (clk),
    .rst       (rst),
    .rdy_in    (rdy_in),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .length    (length),
    .rd        (rd),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .wb_length (wb_length),
    .wb_rd     (wb_rd)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a load at edge 0, then for cycle c drives mem_ready = rp[c] and rdy_in = !hp[c].
  // lat is the cycle in which wb_valid is first seen (-1 on timeout); ends one cycle later in IDLE.
  task automatic do_load(input logic [16:0] b, input logic [31:0] s, input logic [3:0] l,
                         input logic [4:0] r, input logic [31:0] rp, input logic [31:0] hp,
                         input bit inj);
    lat = -1;
    acc_q.delete();
    req_q.delete();
    start = 1'b1; base_addr = b; stride = s; length = l; rd = r;
    rdy_in = 1'b1; mem_ready = 1'b0;
    step();
    start = 1'b0;
    for (int c = 1; c < 32; c++) begin
      mem_ready = rp[c];
      rdy_in    = !hp[c];
      if (inj && c == 2) begin
        start = 1'b1; rd = 5'd3; length = 4'd1; base_addr = 17'h0;
      end else begin
        start = 1'b0;
      end
      if (wb_valid) begin
        lat = c;
        break;
      end
      if (mem_req) req_q.push_back(mem_addr);
      if (mem_req && mem_ready && rdy_in) acc_q.push_back(mem_addr);
      step();
    end
    start = 1'b0; mem_ready = 1'b0; rdy_in = 1'b1;
    if (lat > 0) step();
  endtask

  initial begin
    rst = 1'b1; rdy_in = 1'b1; start = 1'b0; base_addr = '0; stride = '0;
    length = '0; rd = '0; mem_ready = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_len_rd", {wb_length, wb_rd}, 0);
    rst = 1'b0;
    step();

    // Unit load of 8 elements; stride input is non-unit to show it is ignored in the default build.
`ifdef VECTOR_LOAD_STRIDE_EN
    do_load(17'h100, 32'd4, 4'd8, 5'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);
`else
    do_load(17'h100, 32'hFFFF_FFF8, 4'd8, 5'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);
`endif
    check("unit_lat", lat, 9);
    check("unit_nreq", acc_q.size(), 8);
    if (acc_q.size() == 8) begin
      check("unit_addr0", acc_q[0], 17'h100);
      check("unit_addr3", acc_q[3], 17'h10C);
      check("unit_addr7", acc_q[7], 17'h11C);
    end
    check("unit_data", wb_data, {32'h100, 32'h104, 32'h108, 32'h10C,
                                 32'h110, 32'h114, 32'h118, 32'h11C});
    check("unit_len", wb_length, 8);
    check("unit_idle", {busy, wb_valid, mem_req}, 0);

    // Partial load of 3 into rd 5.
    do_load(17'h40, 32'd4, 4'd3, 5'd5, 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("part_lat", lat, 4);
    check("part_nreq", acc_q.size(), 3);
    check("part_data", wb_data, {32'h40, 32'h44, 32'h48, 160'h0});
    check("part_len", wb_length, 3);
    check("part_rd", wb_rd, 5);

    // mem_ready low in cycles 1 and 2: address held for three cycles.
    do_load(17'h80, 32'd4, 4'd2, 5'd2, ~32'h6, 32'h0, 1'b0);
    check("bp_lat", lat, 5);
    check("bp_req_cycles", req_q.size(), 4);
    if (req_q.size() == 4) begin
      check("bp_hold1", req_q[1], 17'h80);
      check("bp_hold2", req_q[2], 17'h80);
      check("bp_next", req_q[3], 17'h84);
    end
    check("bp_data", wb_data, {32'h80, 32'h84, 192'h0});

    // Length 0: immediate write-back, no requests.
    do_load(17'h300, 32'd4, 4'd0, 5'd9, 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("len0_lat", lat, 1);
    check("len0_nreq", req_q.size(), 0);
    check("len0_data", wb_data, 0);
    check("len0_len_rd", {wb_length, wb_rd}, {4'd0, 5'd9});

    // Length 12 clamps to 8.
    do_load(17'h0, 32'd4, 4'd12, 5'd4, 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("clamp_lat", lat, 9);
    check("clamp_nreq", acc_q.size(), 8);
    check("clamp_len", wb_length, 8);
    check("clamp_data", wb_data, {32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C});

    // rdy_in low in cycles 2..4 with mem_ready high: nothing captured, latency +3.
    do_load(17'h20, 32'd4, 4'd2, 5'd6, 32'hFFFF_FFFF, 32'h1C, 1'b0);
    check("frz_lat", lat, 6);
    check("frz_nreq", acc_q.size(), 2);
    check("frz_data", wb_data, {32'h20, 32'h24, 192'h0});

    // start while busy must not disturb the running load.
    do_load(17'h60, 32'd4, 4'd4, 5'd7, 32'hFFFF_FFFF, 32'h0, 1'b1);
    check("busy_start_lat", lat, 5);
    check("busy_start_rd", wb_rd, 7);
    check("busy_start_len", wb_length, 4);
    check("busy_start_idle", busy, 0);

`ifdef VECTOR_LOAD_STRIDE_EN
    do_load(17'h200, 32'hFFFF_FFF8, 4'd4, 5'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("neg_nreq", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      check("neg_addr1", acc_q[1], 17'h1F8);
      check("neg_addr2", acc_q[2], 17'h1F0);
      check("neg_addr3", acc_q[3], 17'h1E8);
    end
    do_load(17'h4, 32'hFFFF_FFF8, 4'd2, 5'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("wrap_nreq", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check("wrap_addr0", acc_q[0], 17'h4);
      check("wrap_addr1", acc_q[1], 17'h1FFFC);
    end
`endif

    // Reset during element 4 of an 8-element load.
    start = 1'b1; base_addr = 17'h100; stride = 32'd4; length = 4'd8; rd = 5'd11;
    mem_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("mid_addr", mem_addr, 17'h110);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    check("mid_rst_ctrl", {busy, mem_req, wb_valid}, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_data", wb_data, 0);
    check("mid_rst_len_rd", {wb_length, wb_rd}, 0);
    rst = 1'b0; mem_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_load_gather.md
# vector_load_gather

Multi-cycle vector load engine that fetches up to `VECTOR_SIZE` 32-bit elements from data memory, one element per memory handshake, and packs them into a full vector word. Sits in the memory-access stage directly upstream of the vector register file. It hands the packed vector, the destination index and the active element count to write-back as a one-cycle `wb_valid` pulse. Element packing matches the register file's partial-write rule: element 0 sits in the most-significant `LEN` bits, so a write of `length` elements updates exactly the loaded slots.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: memory byte-address width
- `LEN`, 32: element width in bits
- `VECTOR_SIZE`, 8: elements per vector register
- `ENTRY_INDEX_SIZE`, 3: log2(`VECTOR_SIZE`); length fields are `ENTRY_INDEX_SIZE+1` bits wide so `VECTOR_SIZE` itself is representable

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rdy_in`  in  1  global enable; when low, all state and outputs hold
- `start`  in  1  request a vector load; accepted only in IDLE
- `base_addr`  in  ADDR_WIDTH  byte address of element 0
- `stride`  in  LEN  signed byte stride between elements (see Configuration)
- `length`  in  ENTRY_INDEX_SIZE+1  element count requested
- `rd`  in  5  destination vector register index
- `mem_req`  out  1  memory read request
- `mem_addr`  out  ADDR_WIDTH  read address, stable while `mem_req` is high
- `mem_rdata`  in  LEN  read data, valid in the cycle `mem_ready` is high
- `mem_ready`  in  1  memory completes the current request this cycle
- `busy`  out  1  high in every state other than IDLE
- `wb_valid`  out  1  one-cycle pulse: result ready for register-file write
- `wb_data`  out  VECTOR_SIZE*LEN  packed vector
- `wb_length`  out  ENTRY_INDEX_SIZE+1  elements actually loaded
- `wb_rd`  out  5  latched destination index

## Operation
- States: IDLE, FETCH, DONE.
- IDLE, `start`=1:
  - Latch `base_addr`, `stride`, `rd`.
  - Latch `length` clamped to `VECTOR_SIZE` (values > `VECTOR_SIZE` become `VECTOR_SIZE`).
  - Clear element counter `idx` and data buffer to 0.
  - Next state is FETCH if clamped length > 0, otherwise DONE.
- FETCH:
  - `mem_req`=1, `mem_addr` = base + idx*stride, modulo 2^ADDR_WIDTH. Stride is sign-extended or truncated to ADDR_WIDTH.
  - On `mem_ready`=1: store `mem_rdata` into slot idx, at bits [(VECTOR_SIZE-idx)*LEN-1 -: LEN], then increment idx.
  - When idx reaches the latched length, go to DONE. Otherwise stay in FETCH with `mem_req` held high and the new address presented the next cycle (back-to-back).
  - `mem_req` is never dropped before `mem_ready` is seen.
- DONE: `wb_valid`=1 for exactly one cycle, then IDLE.
  - `wb_data` holds the buffer; unloaded slots read 0.
  - `wb_length` holds the clamped length; `wb_rd` holds the latched rd.
- `start` while busy is ignored; no queueing.
- `wb_data`, `wb_length` and `wb_rd` stay stable from DONE until the next accepted `start`.
- `mem_ready` outside FETCH is ignored.

## Timing
- Reset values: state IDLE; `busy`=0, `mem_req`=0, `mem_addr`=0, `wb_valid`=0, `wb_data`=0, `wb_length`=0, `wb_rd`=0.
- Reset mid-load: the next edge forces IDLE and reset values. An outstanding memory response is dropped.
- `start` is sampled at edge 0; FETCH begins cycle 1.
- With `mem_ready` always high, length n>0 completes in n FETCH cycles; `wb_valid` is asserted in cycle n+1.
- Length 0: `wb_valid` is asserted in cycle 1 with `wb_length`=0 and no memory request.
- Each cycle with `mem_ready`=0 in FETCH adds one cycle of latency.
- `rdy_in`=0 freezes the FSM, counters and outputs, including a held `wb_valid`. A response with `mem_ready`=1 while `rdy_in`=0 is not captured; memory must hold it.
- Minimum start-to-start interval is n+2 cycles.

## Configuration
- `VECTOR_LOAD_STRIDE_EN` defined: address for element i is base + i*stride, using the signed `stride` input.
- Not defined: unit-stride only. Address is base + i*(LEN/8); `stride` is ignored and its latch is not built.

## Test plan
- Unit load, `mem_ready` always 1, `base_addr`=0x100, length=8, memory word at addr a = a: addresses 0x100,0x104,…,0x11C on consecutive cycles. `wb_valid` in cycle 9. `wb_data` MSB slot = 0x100, LSB slot = 0x11C, `wb_length`=8.
- Partial load, length=3, rd=5: three requests. `wb_length`=3, `wb_rd`=5, lower five slots are 0.
- Backpressure, length=2, `mem_ready` low for 2 cycles on element 0: `mem_addr` is held stable over those cycles. `wb_valid` in cycle 5.
- Edge lengths: length=0 gives `wb_valid` in cycle 1, `wb_data`=0 and no `mem_req`. length=12 is clamped to 8 requests with `wb_length`=8.
- Control: `rst` asserted during element 4 gives IDLE and all-zero outputs next cycle. `start` while busy does not change the latched rd. `rdy_in` low for 3 cycles in FETCH extends latency by 3.
- With `VECTOR_LOAD_STRIDE_EN`, `stride`=-8, base=0x200, length=4: addresses 0x200, 0x1F8, 0x1F0, 0x1E8. With base=0x4, `stride`=-8, length=2: addresses 0x4, 0x1FFFC (wrap).
